mult: RTL

- Sequential signed 32x32 multiplier using radix-2 Booth recoding.
- Produces a 64-bit product split into HI and LO.
- Companion to the datapath's sequential divider. Shares the same operand sources (A/B registers), HI/LO destination registers and level-held Ctrl/Done handshake, so the control unit drives both blocks identically.
- Used by the mult instruction.

---
 rtl/mult_if.sv | 14 +
 rtl/mult.sv | 89 ++++++++
 2 files changed

// File: rtl/mult_if.sv
// Operand/result bundle shared between the control unit and the sequential multiplier.
interface mult_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] RegAOut;
  logic [WIDTH-1:0] RegBOut;
  logic             MultCtrl;
  logic             MultDone;
  logic [WIDTH-1:0] MultHIOut;
  logic [WIDTH-1:0] MultLOOut;

  modport master (output RegAOut, RegBOut, MultCtrl,
                  input  MultDone, MultHIOut, MultLOOut);
  modport slave  (input  RegAOut, RegBOut, MultCtrl,
                  output MultDone, MultHIOut, MultLOOut);
endinterface

// File: rtl/mult.sv
// Sequential signed WIDTHxWIDTH radix-2 Booth multiplier, one recoding step per cycle,
// with the level-held Ctrl/Done handshake used by the companion divider.
module mult #(
  parameter int WIDTH = 32
) (
  input logic  clock,
  input logic  reset,
  mult_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] m, q, hi, lo;
  logic [WIDTH:0]   acc, msx, sum;
  logic             qm1, done, last;
  logic [CW-1:0]    cnt;

  // Add/sub is WIDTH+1 wide so the most negative multiplicand cannot overflow.
  always_comb begin
    msx = {m[WIDTH-1], m};
    sum = acc;
    case ({q[0], qm1})
      2'b01:   sum = acc + msx;
      2'b10:   sum = acc - msx;
      default: sum = acc;
    endcase
    last = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.MultCtrl) state_nxt = RUN;
      RUN:     if (!bus.MultCtrl) state_nxt = IDLE;
               else if (last)     state_nxt = DONE;
      DONE:    if (!bus.MultCtrl) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m    <= '0;
      q    <= '0;
      acc  <= '0;
      qm1  <= 1'b0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.MultCtrl) begin
          m    <= bus.RegAOut;
          q    <= bus.RegBOut;
          acc  <= '0;
          qm1  <= 1'b0;
          cnt  <= '0;
          done <= 1'b0;
        end
        // A dropped request abandons the operation without publishing a partial product.
        RUN: if (bus.MultCtrl) begin
          acc <= {sum[WIDTH], sum[WIDTH:1]};
          q   <= {sum[0], q[WIDTH-1:1]};
          qm1 <= q[0];
          cnt <= cnt + CW'(1);
          if (last) begin
            hi   <= sum[WIDTH:1];
            lo   <= {sum[0], q[WIDTH-1:1]};
            done <= 1'b1;
          end
        end
        DONE: if (!bus.MultCtrl) done <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.MultDone  = done;
  assign bus.MultHIOut = hi;
  assign bus.MultLOOut = lo;
endmodule
